// File: rtl/dac_axis_buffer.sv
// Show-ahead sample FIFO between a DDS source and the RFDC DAC AXI-Stream port.
// Output streams once PRIME_LEVEL words are buffered and re-primes on the first starved beat.
module dac_axis_buffer #(
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int FIFO_DEPTH      = 8,
  parameter int PRIME_LEVEL     = 4,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                         m00_axis_aclk,
  input  logic                         m00_axis_aresetn,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         flush,
  input  logic                         mute,
  input  logic                         clear_counts,
  output logic [AXIS_DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic                         m00_axis_tvalid,
  input  logic                         m00_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [COUNT_WIDTH-1:0]       underflow_count,
  output logic [COUNT_WIDTH-1:0]       overflow_count,
  output logic                         streaming
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {PRIME, STREAM} state_t;

  state_t                     state;
  logic [AXIS_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W-1:0]           wr_ptr;
  logic                       full;
  logic                       empty;
  logic                       pop;
  logic                       push;
  logic                       underflow;
  logic                       overflow;

  assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign empty     = (fifo_level == '0);
  assign pop       = (state == STREAM) && m00_axis_tready && !empty;
  assign underflow = (state == STREAM) && m00_axis_tready && empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push      = s_axis_tvalid && !flush && (!full || pop);
  assign overflow  = s_axis_tvalid && !flush && full && !pop;

  // Head word is presented straight from storage so the first beat has no extra latency.
  assign m00_axis_tdata = ((state == STREAM) && !mute && !empty) ? mem[rd_ptr] : '0;

  // NOTE: sample storage has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge m00_axis_aclk) begin
    if (push) begin
      mem[wr_ptr] <= s_axis_tdata;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn || flush) begin
      state           <= PRIME;
      streaming       <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      fifo_level      <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LVL_W'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LVL_W'(1);
      end

      case (state)
        PRIME: begin
          if (fifo_level >= LVL_W'(PRIME_LEVEL)) begin
            state           <= STREAM;
            streaming       <= 1'b1;
            m00_axis_tvalid <= 1'b1;
          end
        end
        STREAM: begin
          if (underflow) begin
            state           <= PRIME;
            streaming       <= 1'b0;
            m00_axis_tvalid <= 1'b0;
          end
        end
        default: begin
          state           <= PRIME;
          streaming       <= 1'b0;
          m00_axis_tvalid <= 1'b0;
        end
      endcase
    end
  end

  // Error counters survive a flush; clear beats any coincident event.
  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn || clear_counts) begin
      underflow_count <= '0;
      overflow_count  <= '0;
    end else begin
      if (underflow && (underflow_count != '1)) begin
        underflow_count <= underflow_count + COUNT_WIDTH'(1);
      end
      if (overflow && (overflow_count != '1)) begin
        overflow_count <= overflow_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_dac_axis_buffer.sv
// Bench for dac_axis_buffer: directed scenarios plus randomized traffic against a queue model;
// a second narrow-counter instance exercises counter saturation in a practical number of cycles.
`timescale 1ns/1ps
module tb_dac_axis_buffer;

  localparam int W     = 256;
  localparam int DEPTH = 8;
  localparam int PRIME = 4;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  s_tdata;
  logic          s_tvalid, flush, mute, clear_counts, tready;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid, streaming;
  logic [3:0]    level;
  logic [CW-1:0] ucnt, ocnt;

  logic [15:0]   s2_tdata;
  logic          s2_tvalid = 1'b0, s2_flush = 1'b0, s2_mute = 1'b0, s2_clear = 1'b0, s2_tready = 1'b0;
  logic [15:0]   m2_tdata;
  logic          m2_tvalid, streaming2;
  logic [2:0]    level2;
  logic [3:0]    ucnt2, ocnt2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: words in flight, streaming flag and the two counters.
  logic [W-1:0] mq[$];
  bit           ms;
  int           mu, mo;

  always #5 clk = ~clk;

  dac_axis_buffer #(
    .AXIS_DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PRIME), .COUNT_WIDTH(CW)
  ) dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .flush(flush), .mute(mute), .clear_counts(clear_counts),
    .m00_axis_tdata(m_tdata), .m00_axis_tvalid(m_tvalid), .m00_axis_tready(tready),
    .fifo_level(level), .underflow_count(ucnt), .overflow_count(ocnt), .streaming(streaming)
  );

  dac_axis_buffer #(
    .AXIS_DATA_WIDTH(16), .FIFO_DEPTH(4), .PRIME_LEVEL(1), .COUNT_WIDTH(4)
  ) dut_sat (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n),
    .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid),
    .flush(s2_flush), .mute(s2_mute), .clear_counts(s2_clear),
    .m00_axis_tdata(m2_tdata), .m00_axis_tvalid(m2_tvalid), .m00_axis_tready(s2_tready),
    .fifo_level(level2), .underflow_count(ucnt2), .overflow_count(ocnt2), .streaming(streaming2)
  );

  task automatic model_update();
    int sz;
    bit do_pop, do_under, drop, next_ms;
    if (!rst_n) begin
      mq.delete(); ms = 0; mu = 0; mo = 0;
      return;
    end
    sz       = mq.size();
    do_pop   = ms && tready && (sz > 0);
    do_under = ms && tready && (sz == 0);
    drop     = 0;
    if (flush)    next_ms = 0;
    else if (!ms) next_ms = (sz >= PRIME);
    else          next_ms = !do_under;
    if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (s_tvalid) begin
        if (sz < DEPTH || do_pop) mq.push_back(s_tdata);
        else drop = 1;
      end
    end
    if (clear_counts) begin
      mu = 0; mo = 0;
    end else begin
      if (do_under && mu < CMAX) mu++;
      if (drop && mo < CMAX) mo++;
    end
    ms = next_ms;
  endtask

  function automatic logic [W-1:0] exp_tdata();
    if (ms && !mute && mq.size() > 0) return mq[0];
    return '0;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int k = 0; k < W / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [W-1:0] d, input logic r,
                        input logic f, input logic m, input logic c);
    s_tvalid = v; s_tdata = d; tready = r; flush = f; mute = m; clear_counts = c;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1, W'(32'hDEAD), 1, 0, 0, 0);
    tick(); tick();
    n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %0b expected 0", m_tvalid); end
    n_cmp++; if (m_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %0h expected 0", m_tdata); end
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_cmp++; if (streaming !== 1'b0) begin n_fail++; $display("FAIL reset_streaming: got %0b expected 0", streaming); end
    n_cmp++; if (ucnt !== '0 || ocnt !== '0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", ucnt, ocnt); end
    rst_n = 1'b1;
    set_in(0, '0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_priming_underflow();
    for (int i = 1; i <= 4; i++) begin
      set_in(1, W'(i), 1, 0, 0, 0);
      n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL prime_tvalid_early[%0d]: got %0b expected 0", i, m_tvalid); end
      tick();
    end
    set_in(0, '0, 1, 0, 0, 0);
    n_cmp++; if (level !== 4'd4) begin n_fail++; $display("FAIL prime_level: got %0d expected 4", level); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL prime_tvalid_at_level: got %0b expected 0", m_tvalid); end
    tick();
    for (int i = 1; i <= 4; i++) begin
      set_in(0, '0, 1, 0, 0, 0);
      n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== W'(i)) begin
        n_fail++; $display("FAIL prime_beat[%0d]: got v=%0b d=%0h expected v=1 d=%0h", i, m_tvalid, m_tdata, i);
      end
      tick();
    end
    set_in(0, '0, 1, 0, 0, 0);
    n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== '0) begin
      n_fail++; $display("FAIL underflow_beat: got v=%0b d=%0h expected v=1 d=0", m_tvalid, m_tdata);
    end
    tick();
    set_in(0, '0, 1, 0, 0, 0);
    n_cmp++; if (ucnt !== 16'd1) begin n_fail++; $display("FAIL underflow_count: got %0d expected 1", ucnt); end
    n_cmp++; if (streaming !== 1'b0 || m_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL underflow_reprime: got s=%0b v=%0b expected 0/0", streaming, m_tvalid);
    end
  endtask

  task automatic test_overflow();
    int o_before = mo;
    for (int i = 1; i <= 10; i++) begin
      set_in(1, W'(32'hA0 + i), 0, 0, 0, 0);
      tick();
    end
    set_in(0, '0, 0, 0, 0, 0);
    n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d expected 8", level); end
    n_cmp++; if (ocnt !== CW'(o_before + 2)) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", ocnt, o_before + 2); end
    n_cmp++; if (streaming !== 1'b1) begin n_fail++; $display("FAIL ovf_streaming: got %0b expected 1", streaming); end
    tick();
    set_in(0, '0, 0, 0, 0, 0);
    n_cmp++; if (m_tdata !== W'(32'hA1)) begin n_fail++; $display("FAIL ovf_hold: got %0h expected a1", m_tdata); end
    for (int i = 1; i <= 8; i++) begin
      set_in(0, '0, 1, 0, 0, 0);
      n_cmp++; if (m_tdata !== W'(32'hA0 + i)) begin
        n_fail++; $display("FAIL ovf_drain[%0d]: got %0h expected %0h", i, m_tdata, 32'hA0 + i);
      end
      tick();
    end
    set_in(0, '0, 1, 0, 0, 0);
    n_cmp++; if (m_tdata !== '0) begin n_fail++; $display("FAIL ovf_dropped_absent: got %0h expected 0", m_tdata); end
    tick();
  endtask

  task automatic test_full_push_pop();
    int o_before = mo;
    logic [W-1:0] exp;
    for (int i = 1; i <= 8; i++) begin
      set_in(1, W'(32'hB0 + i), 0, 0, 0, 0);
      tick();
    end
    set_in(1, W'(32'hC0), 1, 0, 0, 0);
    n_cmp++; if (m_tdata !== W'(32'hB1)) begin n_fail++; $display("FAIL fpp_head: got %0h expected b1", m_tdata); end
    tick();
    set_in(0, '0, 0, 0, 0, 0);
    n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL fpp_level: got %0d expected 8", level); end
    n_cmp++; if (ocnt !== CW'(o_before)) begin n_fail++; $display("FAIL fpp_ovf: got %0d expected %0d", ocnt, o_before); end
    for (int i = 2; i <= 9; i++) begin
      exp = (i <= 8) ? W'(32'hB0 + i) : W'(32'hC0);
      set_in(0, '0, 1, 0, 0, 0);
      n_cmp++; if (m_tdata !== exp) begin n_fail++; $display("FAIL fpp_drain[%0d]: got %0h expected %0h", i, m_tdata, exp); end
      tick();
    end
    set_in(0, '0, 1, 0, 0, 0);
    tick();
  endtask

  task automatic test_flush_push();
    int o_before = mo;
    for (int i = 1; i <= 8; i++) begin
      set_in(1, W'(32'hF0 + i), 0, 0, 0, 0);
      tick();
    end
    set_in(1, W'(32'hEE), 0, 1, 0, 0);
    n_cmp++; if (streaming !== 1'b1 || level !== 4'd8) begin
      n_fail++; $display("FAIL flush_pre: got s=%0b lvl=%0d expected 1/8", streaming, level);
    end
    tick();
    set_in(0, '0, 1, 0, 0, 0);
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL flush_level: got %0d expected 0", level); end
    n_cmp++; if (m_tvalid !== 1'b0 || streaming !== 1'b0) begin
      n_fail++; $display("FAIL flush_state: got v=%0b s=%0b expected 0/0", m_tvalid, streaming);
    end
    n_cmp++; if (ocnt !== CW'(o_before)) begin n_fail++; $display("FAIL flush_ovf: got %0d expected %0d", ocnt, o_before); end
    tick();
  endtask

  task automatic test_mute();
    for (int i = 1; i <= 4; i++) begin
      set_in(1, W'(32'hD0 + i), 1, 0, 1, 0);
      tick();
    end
    set_in(0, '0, 1, 0, 1, 0);
    tick();
    for (int i = 1; i <= 2; i++) begin
      set_in(0, '0, 1, 0, 1, 0);
      n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== '0 || level !== 4'(5 - i)) begin
        n_fail++; $display("FAIL mute_beat[%0d]: got v=%0b d=%0h lvl=%0d expected 1/0/%0d", i, m_tvalid, m_tdata, level, 5 - i);
      end
      tick();
    end
    for (int i = 3; i <= 4; i++) begin
      set_in(0, '0, 1, 0, 0, 0);
      n_cmp++; if (m_tdata !== W'(32'hD0 + i)) begin
        n_fail++; $display("FAIL unmute_beat[%0d]: got %0h expected %0h", i, m_tdata, 32'hD0 + i);
      end
      tick();
    end
    set_in(0, '0, 1, 0, 0, 0);
    tick();
  endtask

  task automatic test_clear_vs_underflow();
    for (int i = 1; i <= 4; i++) begin
      set_in(1, W'(32'hE0 + i), 1, 0, 0, 0);
      tick();
    end
    set_in(0, '0, 1, 0, 0, 0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      set_in(0, '0, 1, 0, 0, 0);
      tick();
    end
    set_in(0, '0, 1, 0, 0, 1);
    n_cmp++; if (ucnt !== CW'(mu) || mu == 0) begin
      n_fail++; $display("FAIL clear_pre_count: got %0d expected %0d (nonzero)", ucnt, mu);
    end
    tick();
    set_in(0, '0, 0, 0, 0, 0);
    n_cmp++; if (ucnt !== '0 || ocnt !== '0) begin
      n_fail++; $display("FAIL clear_counts: got %0d/%0d expected 0/0", ucnt, ocnt);
    end
    n_cmp++; if (streaming !== 1'b0) begin n_fail++; $display("FAIL clear_reprime: got %0b expected 0", streaming); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 1; i <= 4; i++) begin
      set_in(1, W'(32'h70 + i), 0, 0, 0, 0);
      tick();
    end
    set_in(0, '0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (streaming !== 1'b1 || level !== 4'd4) begin
      n_fail++; $display("FAIL rst_mid_pre: got s=%0b lvl=%0d expected 1/4", streaming, level);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_in(0, '0, 1, 0, 0, 0);
    n_cmp++; if (m_tvalid !== 1'b0 || m_tdata !== '0 || level !== 4'd0 || streaming !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: got v=%0b d=%0h lvl=%0d s=%0b expected 0/0/0/0", m_tvalid, m_tdata, level, streaming);
    end
    tick();
    set_in(0, '0, 1, 0, 0, 0);
    n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: got %0b expected 0", m_tvalid); end
  endtask

  task automatic test_random();
    int push_pct, rdy_pct;
    logic [W-1:0] exp;
    for (int c = 0; c < 1600; c++) begin
      case ((c / 160) % 4)
        0:       begin push_pct = 90;  rdy_pct = 30; end
        1:       begin push_pct = 30;  rdy_pct = 90; end
        2:       begin push_pct = 60;  rdy_pct = 60; end
        default: begin push_pct = 100; rdy_pct = 50; end
      endcase
      set_in($urandom_range(0, 99) < push_pct, rand_word(), $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0);
      exp = exp_tdata();
      n_cmp++; if (m_tvalid !== ms || streaming !== ms) begin
        n_fail++; $display("FAIL rnd_valid[%0d]: got v=%0b s=%0b expected %0b", c, m_tvalid, streaming, ms);
      end
      n_cmp++; if (level !== 4'(mq.size())) begin
        n_fail++; $display("FAIL rnd_level[%0d]: got %0d expected %0d", c, level, mq.size());
      end
      n_cmp++; if (m_tdata !== exp) begin
        n_fail++; $display("FAIL rnd_tdata[%0d]: got %0h expected %0h", c, m_tdata, exp);
      end
      n_cmp++; if (ucnt !== CW'(mu) || ocnt !== CW'(mo)) begin
        n_fail++; $display("FAIL rnd_counts[%0d]: got %0d/%0d expected %0d/%0d", c, ucnt, ocnt, mu, mo);
      end
      tick();
    end
    set_in(0, '0, 0, 1, 0, 0);
    tick();
    set_in(0, '0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    s2_tready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s2_tvalid = 1'b1; s2_tdata = 16'(k + 1);
      tick();
      s2_tvalid = 1'b0;
      tick(); tick(); tick();
      if (k == 13) begin
        n_cmp++; if (ucnt2 !== 4'd14) begin n_fail++; $display("FAIL sat_under_mid: got %0d expected 14", ucnt2); end
      end
    end
    n_cmp++; if (ucnt2 !== 4'hF) begin n_fail++; $display("FAIL sat_under: got %0d expected 15", ucnt2); end
    n_cmp++; if (streaming2 !== 1'b0) begin n_fail++; $display("FAIL sat_reprime: got %0b expected 0", streaming2); end
    s2_tready = 1'b0;
    for (int k = 0; k < 24; k++) begin
      s2_tvalid = 1'b1; s2_tdata = 16'(16'h100 + k);
      tick();
      if (k == 13) begin
        n_cmp++; if (ocnt2 !== 4'd10) begin n_fail++; $display("FAIL sat_over_mid: got %0d expected 10", ocnt2); end
      end
    end
    n_cmp++; if (ocnt2 !== 4'hF || level2 !== 3'd4) begin
      n_fail++; $display("FAIL sat_over: got cnt=%0d lvl=%0d expected 15/4", ocnt2, level2);
    end
    s2_clear = 1'b1;
    tick();
    s2_clear = 1'b0; s2_tvalid = 1'b0;
    #1;
    n_cmp++; if (ocnt2 !== 4'd0 || ucnt2 !== 4'd0) begin
      n_fail++; $display("FAIL sat_clear: got %0d/%0d expected 0/0", ocnt2, ucnt2);
    end
    s2_flush = 1'b1;
    tick();
    s2_flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    s2_tdata = '0;
    set_in(0, '0, 0, 0, 0, 0);
    test_reset();
    test_priming_underflow();
    test_overflow();
    test_full_push_pop();
    test_flush_push();
    test_mute();
    test_clear_vs_underflow();
    test_reset_midstream();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
